// File: rtl/mips_ctrl_ext_alu.sv
// Multicycle control FSM, immediate extender and ALU of the MIPS core.
// Define CTRL_BYTE_HALF_EN to decode lb/lbu/lh/lhu/sb/sh.
module mips_ctrl_ext_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic [15:0]      imm,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] default_next_pc,
  output logic [1:0]       ext_mode,
  output logic             alu_src,
  output logic             alu_src_0,
  output logic [1:0]       alu_mode,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       mem_width,
  output logic             mem_signext,
  output logic             reg_write,
  output logic [1:0]       wb_idx,
  output logic [1:0]       wb_src,
  output logic             pc_write,
  output logic [1:0]       next_pc_src,
  output logic [WIDTH-1:0] extended_imm,
  output logic [WIDTH-1:0] alu_result,
  output logic             zf
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [1:0] A_ADD  = 2'd0;
  localparam logic [1:0] A_SUB  = 2'd1;
  localparam logic [1:0] A_OR   = 2'd2;
  localparam logic [1:0] A_PASS = 2'd3;

  state_t state, state_n;

  logic c_alu, c_load, c_store, c_jump, c_jal;
  logic pc_w, rw, mr, mw;

  always_comb begin
    ext_mode    = 2'd0;
    alu_src     = 1'b0;
    alu_src_0   = 1'b0;
    alu_mode    = A_ADD;
    mem_width   = 2'd2;
    mem_signext = 1'b0;
    wb_idx      = 2'd0;
    wb_src      = 2'd0;
    next_pc_src = 2'd0;
    c_alu       = 1'b0;
    c_load      = 1'b0;
    c_store     = 1'b0;
    c_jump      = 1'b0;
    c_jal       = 1'b0;
    case (opcode)
      6'h00: begin
        wb_idx = 2'd1;
        case (func)
          6'h21: c_alu = 1'b1;
          6'h23: begin
            c_alu    = 1'b1;
            alu_mode = A_SUB;
          end
          6'h25: begin
            c_alu    = 1'b1;
            alu_mode = A_OR;
          end
          6'h08: begin
            c_jump      = 1'b1;
            alu_mode    = A_PASS;
            next_pc_src = 2'd1;
          end
          default: ;
        endcase
      end
      6'h09: begin
        c_alu    = 1'b1;
        ext_mode = 2'd1;
        alu_src  = 1'b1;
      end
      6'h0D: begin
        c_alu    = 1'b1;
        alu_src  = 1'b1;
        alu_mode = A_OR;
      end
      6'h0F: begin
        c_alu    = 1'b1;
        ext_mode = 2'd2;
        alu_src  = 1'b1;
        alu_mode = A_OR;
      end
      6'h23: begin
        c_load   = 1'b1;
        ext_mode = 2'd1;
        alu_src  = 1'b1;
        wb_src   = 2'd1;
      end
      6'h2B: begin
        c_store  = 1'b1;
        ext_mode = 2'd1;
        alu_src  = 1'b1;
      end
      6'h04: begin
        c_jump      = 1'b1;
        ext_mode    = 2'd1;
        alu_mode    = A_SUB;
        next_pc_src = 2'd2;
      end
      6'h02: begin
        c_jump      = 1'b1;
        next_pc_src = 2'd3;
      end
      6'h03: begin
        c_jump      = 1'b1;
        c_jal       = 1'b1;
        next_pc_src = 2'd3;
        wb_idx      = 2'd2;
        wb_src      = 2'd2;
        alu_src_0   = 1'b1;
        alu_mode    = A_PASS;
      end
`ifdef CTRL_BYTE_HALF_EN
      6'h20, 6'h24, 6'h21, 6'h25: begin
        c_load      = 1'b1;
        ext_mode    = 2'd1;
        alu_src     = 1'b1;
        wb_src      = 2'd1;
        mem_width   = {1'b0, opcode[0]};
        mem_signext = ~opcode[2];
      end
      6'h28, 6'h29: begin
        c_store   = 1'b1;
        ext_mode  = 2'd1;
        alu_src   = 1'b1;
        mem_width = {1'b0, opcode[0]};
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    case (ext_mode)
      2'd1:    extended_imm = {{(WIDTH-16){imm[15]}}, imm};
      2'd2:    extended_imm = {imm, {(WIDTH-16){1'b0}}};
      default: extended_imm = {{(WIDTH-16){1'b0}}, imm};
    endcase
  end

  logic [WIDTH-1:0] op_a, op_b;

  assign op_a = alu_src_0 ? default_next_pc : rs_data;
  assign op_b = alu_src ? extended_imm : rt_data;

  always_comb begin
    case (alu_mode)
      A_ADD:   alu_result = op_a + op_b;
      A_SUB:   alu_result = op_a - op_b;
      A_OR:    alu_result = op_a | op_b;
      default: alu_result = op_a;
    endcase
  end

  assign zf = (alu_result == '0);

  always_ff @(posedge clock) begin
    if (reset) state <= S_IF;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    pc_w    = 1'b0;
    rw      = 1'b0;
    mr      = 1'b0;
    mw      = 1'b0;
    case (state)
      S_IF: state_n = S_ID;
      S_ID: begin
        if (c_alu | c_load | c_store | c_jump) begin
          state_n = S_EX;
        end else begin
          state_n = S_IF;
          pc_w    = 1'b1;
        end
      end
      S_EX: begin
        if (c_alu) begin
          state_n = S_WB;
        end else if (c_load | c_store) begin
          state_n = S_MEM;
        end else begin
          state_n = S_IF;
          pc_w    = 1'b1;
          rw      = c_jal;
        end
      end
      S_MEM: begin
        if (c_load) begin
          state_n = S_WB;
          mr      = 1'b1;
        end else begin
          state_n = S_IF;
          mw      = 1'b1;
          pc_w    = 1'b1;
        end
      end
      S_WB: begin
        state_n = S_IF;
        rw      = 1'b1;
        mr      = c_load;
        pc_w    = 1'b1;
      end
      default: state_n = S_IF;
    endcase
  end

  // strobes are suppressed in any reset cycle, even mid-instruction
  assign pc_write  = pc_w & ~reset;
  assign reg_write = rw & ~reset;
  assign mem_read  = mr & ~reset;
  assign mem_write = mw & ~reset;

endmodule

// File: tb/tb_mips_ctrl_ext_alu.sv
// Randomized self-checking bench for mips_ctrl_ext_alu.
// Built with CTRL_BYTE_HALF_EN undefined.
module tb_mips_ctrl_ext_alu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic [15:0] imm = '0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic [31:0] default_next_pc = '0;
  logic [1:0]  ext_mode;
  logic        alu_src;
  logic        alu_src_0;
  logic [1:0]  alu_mode;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_width;
  logic        mem_signext;
  logic        reg_write;
  logic [1:0]  wb_idx;
  logic [1:0]  wb_src;
  logic        pc_write;
  logic [1:0]  next_pc_src;
  logic [31:0] extended_imm;
  logic [31:0] alu_result;
  logic        zf;

  int n_checks = 0;
  int n_fail = 0;

  mips_ctrl_ext_alu #(.WIDTH(32)) dut (
    .clock(clock),
    .reset(reset),
    .opcode(opcode),
    .func(func),
    .imm(imm),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .default_next_pc(default_next_pc),
    .ext_mode(ext_mode),
    .alu_src(alu_src),
    .alu_src_0(alu_src_0),
    .alu_mode(alu_mode),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_width(mem_width),
    .mem_signext(mem_signext),
    .reg_write(reg_write),
    .wb_idx(wb_idx),
    .wb_src(wb_src),
    .pc_write(pc_write),
    .next_pc_src(next_pc_src),
    .extended_imm(extended_imm),
    .alu_result(alu_result),
    .zf(zf)
  );

  always #5 clock = ~clock;

  typedef enum int {
    K_ADDU, K_SUBU, K_OR, K_JR, K_ADDIU, K_ORI, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD
  } kind_t;

  logic [5:0] bad_ops [5] = '{6'h20, 6'h21, 6'h24, 6'h3F, 6'h05};

  // Called at a falling edge with the FSM in IF; returns at the
  // falling edge that begins the next instruction.
  task automatic run_instr(input kind_t k, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] im,
                           input logic [31:0] npc, input string tag);
    int len, rw_cyc, mr_from, mw_cyc;
    logic [31:0] sx, zx, e_alu, e_ext;
    logic chk_alu, chk_ext, chk_wb, chk_mem;
    logic [1:0] e_em, e_nps, e_wbi, e_wbs;
    logic [3:0] e_st, got_st;
    sx = {{16{im[15]}}, im};
    zx = {16'h0, im};
    len = 2; rw_cyc = 0; mr_from = 0; mw_cyc = 0;
    e_alu = '0; e_ext = '0; e_em = 2'd0; e_nps = 2'd0;
    e_wbi = 2'd0; e_wbs = 2'd0;
    chk_alu = 1'b1; chk_ext = 1'b0; chk_wb = 1'b0; chk_mem = 1'b0;
    opcode = 6'h00; func = 6'h00;
    case (k)
      K_ADDU: begin func = 6'h21; len = 4; rw_cyc = 4;
        e_alu = a + b; e_wbi = 2'd1; chk_wb = 1'b1; end
      K_SUBU: begin func = 6'h23; len = 4; rw_cyc = 4;
        e_alu = a - b; e_wbi = 2'd1; chk_wb = 1'b1; end
      K_OR: begin func = 6'h25; len = 4; rw_cyc = 4;
        e_alu = a | b; e_wbi = 2'd1; chk_wb = 1'b1; end
      K_JR: begin func = 6'h08; len = 3; e_alu = a; e_nps = 2'd1; end
      K_ADDIU: begin opcode = 6'h09; len = 4; rw_cyc = 4;
        e_alu = a + sx; e_ext = sx; e_em = 2'd1;
        chk_ext = 1'b1; chk_wb = 1'b1; end
      K_ORI: begin opcode = 6'h0D; len = 4; rw_cyc = 4;
        e_alu = a | zx; e_ext = zx; chk_ext = 1'b1; chk_wb = 1'b1; end
      K_LUI: begin opcode = 6'h0F; len = 4; rw_cyc = 4;
        e_ext = {im, 16'h0}; e_alu = a | e_ext; e_em = 2'd2;
        chk_ext = 1'b1; chk_wb = 1'b1; end
      K_LW: begin opcode = 6'h23; len = 5; rw_cyc = 5; mr_from = 4;
        e_alu = a + sx; e_ext = sx; e_em = 2'd1; e_wbs = 2'd1;
        chk_ext = 1'b1; chk_wb = 1'b1; chk_mem = 1'b1; end
      K_SW: begin opcode = 6'h2B; len = 4; mw_cyc = 4;
        e_alu = a + sx; e_ext = sx; e_em = 2'd1;
        chk_ext = 1'b1; chk_mem = 1'b1; end
      K_BEQ: begin opcode = 6'h04; len = 3; e_alu = a - b;
        e_ext = sx; e_em = 2'd1; e_nps = 2'd2; chk_ext = 1'b1; end
      K_J: begin opcode = 6'h02; len = 3; e_nps = 2'd3; chk_alu = 1'b0; end
      K_JAL: begin opcode = 6'h03; len = 3; rw_cyc = 3; e_alu = npc;
        e_nps = 2'd3; e_wbi = 2'd2; e_wbs = 2'd2; chk_wb = 1'b1; end
      default: begin
        opcode = bad_ops[$urandom_range(0, 4)];
        len = 2; chk_alu = 1'b0;
      end
    endcase
    imm = im; rs_data = a; rt_data = b; default_next_pc = npc;
    for (int c = 1; c <= len; c++) begin
      #1;
      e_st = {c == len, c == rw_cyc,
              mr_from != 0 && c >= mr_from, c == mw_cyc};
      got_st = {pc_write, reg_write, mem_read, mem_write};
      n_checks++;
      if (got_st !== e_st) begin
        n_fail++;
        $display("FAIL %s strobes cyc%0d: got pc/rw/mr/mw=%b expected %b",
                 tag, c, got_st, e_st);
      end
      if (c == 1 && chk_alu) begin
        n_checks++;
        if (alu_result !== e_alu || zf !== (e_alu == 0)) begin
          n_fail++;
          $display("FAIL %s alu: got %h zf=%b expected %h zf=%b",
                   tag, alu_result, zf, e_alu, e_alu == 0);
        end
        n_checks++;
        if (next_pc_src !== e_nps) begin
          n_fail++;
          $display("FAIL %s nps: got %0d expected %0d",
                   tag, next_pc_src, e_nps);
        end
      end
      if (c == 1 && chk_ext) begin
        n_checks++;
        if (extended_imm !== e_ext || ext_mode !== e_em) begin
          n_fail++;
          $display("FAIL %s ext: got %h mode %0d expected %h mode %0d",
                   tag, extended_imm, ext_mode, e_ext, e_em);
        end
      end
      if (c == 1 && chk_wb) begin
        n_checks++;
        if (wb_idx !== e_wbi || wb_src !== e_wbs) begin
          n_fail++;
          $display("FAIL %s wb: got idx %0d src %0d expected idx %0d src %0d",
                   tag, wb_idx, wb_src, e_wbi, e_wbs);
        end
      end
      if (c == 1 && chk_mem) begin
        n_checks++;
        if (mem_width !== 2'd2 || mem_signext !== 1'b0) begin
          n_fail++;
          $display("FAIL %s memfmt: got w%0d s%b expected w2 s0",
                   tag, mem_width, mem_signext);
        end
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    repeat (2) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({pc_write, reg_write, mem_read, mem_write} !== 4'b0) begin
        n_fail++;
        $display("FAIL reset strobes: got %b expected 0000",
                 {pc_write, reg_write, mem_read, mem_write});
      end
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(K_ADDU, 32'd5, 32'd7, 16'h0, 32'h4, "addu_5_7");
    run_instr(K_BEQ, 32'h1234, 32'h1234, 16'h0010, 32'h8, "beq_eq");
    run_instr(K_BEQ, 32'h1234, 32'h1235, 16'hFFF0, 32'hC, "beq_ne");
    run_instr(K_LUI, 32'h0, 32'h55, 16'hABCD, 32'h10, "lui_abcd");
    run_instr(K_ADDIU, 32'd1, 32'h0, 16'hFFFF, 32'h14, "addiu_wrap");
    run_instr(K_SW, 32'h100, 32'hDEAD, 16'h0008, 32'h18, "sw");
    run_instr(K_LW, 32'h100, 32'h0, 16'hFFFC, 32'h1C, "lw");
    run_instr(K_JAL, 32'h77, 32'h0, 16'h0, 32'h3004, "jal");
    run_instr(K_SUBU, 32'h0, 32'h1, 16'h0, 32'h20, "subu_0_1");
    run_instr(K_ORI, 32'hF0F0_0000, 32'h0, 16'h8001, 32'h24, "ori_zext");
    run_instr(K_JR, 32'h4000, 32'h0, 16'h0, 32'h28, "jr");
    run_instr(K_J, 32'h0, 32'h0, 16'h0, 32'h2C, "j");
    run_instr(K_BAD, 32'h0, 32'h0, 16'h0, 32'h30, "unknown");
  endtask

  task automatic test_reset_mid_instr();
    opcode = 6'h23; func = 6'h0; imm = 16'h4;
    rs_data = 32'h200; rt_data = 32'h0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pc_write, reg_write, mem_read, mem_write} !== 4'b0) begin
      n_fail++;
      $display("FAIL midreset strobes: got %b expected 0000",
               {pc_write, reg_write, mem_read, mem_write});
    end
    @(negedge clock);
    reset = 1'b0;
    run_instr(K_ADDU, 32'd3, 32'd4, 16'h0, 32'h40, "after_midreset");
  endtask

  task automatic test_random();
    kind_t k;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      k = kind_t'($urandom_range(0, 12));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (k == K_LUI) a = '0;
      run_instr(k, a, b, 16'($urandom), $urandom & 32'hFFFF_FFFC,
                $sformatf("rand%0d_k%0d", i, int'(k)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_instr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
